// File: rtl/miner_host_regs.sv
// miner_host_regs: Avalon-MM register bank and job controller for NUM_CORES
// SHA-256 mining cores. Holds the 256-bit target and the 608-bit message,
// hands each core a fixed slice of the nonce space, starts and aborts jobs,
// and latches the first winning nonce (lowest core index wins ties).
// Optional feature macro: MINER_IRQ_EN adds the irq output and IRQ_CTRL at
// word address 31.

module miner_host_regs #(
    parameter int NUM_CORES = 4
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [4:0]                slaveAddr,
    input  logic [31:0]               slaveWriteData,
    input  logic                      slaveWrite,
    input  logic                      slaveRead,
    input  logic                      slaveChipSelect,
    output logic [31:0]               slaveReadData,
    output logic                      coreStart,
    output logic                      coreAbort,
    output logic [607:0]              coreMessage,
    output logic [255:0]              coreTarget,
    output logic [NUM_CORES*32-1:0]   coreNonceBase,
    input  logic [NUM_CORES-1:0]      coreFound,
    input  logic [NUM_CORES*32-1:0]   coreNonce,
    input  logic [NUM_CORES-1:0]      coreDone
`ifdef MINER_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TGT_READY = 3'd1;
    localparam logic [2:0] ST_MINING    = 3'd2;
    localparam logic [2:0] ST_FOUND     = 3'd3;
    localparam logic [2:0] ST_EXHAUSTED = 3'd4;

    localparam logic [31:0] CMD_LOAD  = 32'd1;
    localparam logic [31:0] CMD_START = 32'd2;
    localparam logic [31:0] CMD_ABORT = 32'd3;

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [32:0] NONCE_SPAN = 33'h1_0000_0000 / 33'(NUM_CORES);

    logic                  wr_en;
    logic                  rd_en;
    logic [2:0]            state_q;
    logic [7:0][31:0]      target_q;
    logic [18:0][31:0]     message_q;
    logic [31:0]           nonce_q;
    logic [IDX_W-1:0]      found_core_q;
    logic [NUM_CORES-1:0]  done_mask_q;
    logic [NUM_CORES-1:0]  done_next;
    logic                  found_any;
    logic                  done_all;
    logic                  enter_stop;
    logic [IDX_W-1:0]      hit_idx;
    logic [31:0]           hit_nonce;
    logic                  cmd_load;
    logic                  cmd_start;
    logic                  cmd_abort;
    logic                  is_target_addr;
    logic                  is_message_addr;
    logic [31:0]           rd_word;

`ifdef MINER_IRQ_EN
    logic irq_enable_q;
    logic irq_pending_q;
`endif

    assign wr_en = slaveWrite & slaveChipSelect;
    assign rd_en = slaveRead & slaveChipSelect;

    assign cmd_load  = wr_en && (slaveAddr == 5'd1) && (slaveWriteData == CMD_LOAD);
    assign cmd_start = wr_en && (slaveAddr == 5'd1) && (slaveWriteData == CMD_START);
    assign cmd_abort = wr_en && (slaveAddr == 5'd1) && (slaveWriteData == CMD_ABORT);

    assign is_target_addr  = (slaveAddr >= 5'd2)  && (slaveAddr <= 5'd9);
    assign is_message_addr = (slaveAddr >= 5'd11) && (slaveAddr <= 5'd29);

    assign found_any  = |coreFound;
    assign done_next  = done_mask_q | coreDone;
    assign done_all   = &done_next;
    assign enter_stop = (state_q == ST_MINING) && (found_any || done_all);

    assign coreTarget  = target_q;
    assign coreMessage = message_q;

    // Each core starts its search at an equal fraction of the 32-bit nonce space.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
        localparam logic [32:0] BASE = NONCE_SPAN * 33'(g);
        assign coreNonceBase[g*32 +: 32] = BASE[31:0];
    end

    // Pick the lowest-indexed core reporting a hit, scanning high to low so the lowest overwrites.
    always_comb begin
        hit_idx   = '0;
        hit_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (coreFound[i]) begin
                hit_idx   = IDX_W'(i);
                hit_nonce = coreNonce[i*32 +: 32];
            end
        end
    end

    // Job FSM: start/abort pulses, sticky done mask and winner capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            coreStart    <= 1'b0;
            coreAbort    <= 1'b0;
            done_mask_q  <= '0;
            nonce_q      <= '0;
            found_core_q <= '0;
        end else begin
            coreStart <= 1'b0;
            coreAbort <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_load) state_q <= ST_TGT_READY;
                end
                ST_TGT_READY: begin
                    if (cmd_start) begin
                        state_q     <= ST_MINING;
                        coreStart   <= 1'b1;
                        done_mask_q <= '0;
                    end
                end
                ST_FOUND, ST_EXHAUSTED: begin
                    if (cmd_start) begin
                        state_q     <= ST_MINING;
                        coreStart   <= 1'b1;
                        done_mask_q <= '0;
                    end else if (cmd_load) begin
                        state_q <= ST_TGT_READY;
                    end
                end
                ST_MINING: begin
                    done_mask_q <= done_next;
                    if (found_any) begin
                        state_q      <= ST_FOUND;
                        nonce_q      <= hit_nonce;
                        found_core_q <= hit_idx;
                        coreAbort    <= 1'b1;
                    end else if (done_all) begin
                        state_q <= ST_EXHAUSTED;
                    end else if (cmd_abort) begin
                        state_q   <= ST_TGT_READY;
                        coreAbort <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Host writes to target and message words, frozen while a job is running.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target_q  <= '0;
            message_q <= '0;
        end else if (wr_en && (state_q != ST_MINING)) begin
            if (is_target_addr)
                target_q[3'(slaveAddr - 5'd2)] <= slaveWriteData;
            if (is_message_addr)
                message_q[5'(slaveAddr - 5'd11)] <= slaveWriteData;
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_word = '0;
        if (slaveAddr == 5'd0)
            rd_word = {29'd0, state_q};
        else if (is_target_addr)
            rd_word = target_q[3'(slaveAddr - 5'd2)];
        else if (slaveAddr == 5'd10)
            rd_word = nonce_q;
        else if (is_message_addr)
            rd_word = message_q[5'(slaveAddr - 5'd11)];
        else if (slaveAddr == 5'd30)
            rd_word = {{(32-IDX_W){1'b0}}, found_core_q};
`ifdef MINER_IRQ_EN
        else if (slaveAddr == 5'd31)
            rd_word = {30'd0, irq_pending_q, irq_enable_q};
`endif
    end

    // Registered read data, held until the next accepted read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            slaveReadData <= '0;
        else if (rd_en)
            slaveReadData <= rd_word;
    end

`ifdef MINER_IRQ_EN
    // Interrupt: pending latches on job completion, host clears it; output is registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_enable_q  <= 1'b0;
            irq_pending_q <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (wr_en && (slaveAddr == 5'd31))
                irq_enable_q <= slaveWriteData[0];
            if (enter_stop)
                irq_pending_q <= 1'b1;
            else if (wr_en && (slaveAddr == 5'd31) && slaveWriteData[1])
                irq_pending_q <= 1'b0;
            irq <= irq_enable_q & irq_pending_q;
        end
    end
`endif

endmodule

// File: tb/tb_miner_host_regs.sv
// tb_miner_host_regs: directed, self-checking bench for miner_host_regs with
// four cores. Drives the bus on falling edges and samples on falling edges,
// so every check looks at values settled after the preceding rising edge.

module tb_miner_host_regs;

    localparam int NC = 4;

    logic               clk;
    logic               n_rst;
    logic [4:0]         slaveAddr;
    logic [31:0]        slaveWriteData;
    logic               slaveWrite;
    logic               slaveRead;
    logic               slaveChipSelect;
    logic [31:0]        slaveReadData;
    logic               coreStart;
    logic               coreAbort;
    logic [607:0]       coreMessage;
    logic [255:0]       coreTarget;
    logic [NC*32-1:0]   coreNonceBase;
    logic [NC-1:0]      coreFound;
    logic [NC*32-1:0]   coreNonce;
    logic [NC-1:0]      coreDone;
`ifdef MINER_IRQ_EN
    logic               irq;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] rdata;

    miner_host_regs #(.NUM_CORES(NC)) dut (
`ifdef MINER_IRQ_EN
        .irq             (irq),
`endif
        .clk             (clk),
        .n_rst           (n_rst),
        .slaveAddr       (slaveAddr),
        .slaveWriteData  (slaveWriteData),
        .slaveWrite      (slaveWrite),
        .slaveRead       (slaveRead),
        .slaveChipSelect (slaveChipSelect),
        .slaveReadData   (slaveReadData),
        .coreStart       (coreStart),
        .coreAbort       (coreAbort),
        .coreMessage     (coreMessage),
        .coreTarget      (coreTarget),
        .coreNonceBase   (coreNonceBase),
        .coreFound       (coreFound),
        .coreNonce       (coreNonce),
        .coreDone        (coreDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus write; returns on the falling edge right after the sampling edge.
    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        slaveAddr       = addr;
        slaveWriteData  = data;
        slaveWrite      = 1'b1;
        slaveChipSelect = 1'b1;
        @(negedge clk);
        slaveWrite      = 1'b0;
        slaveChipSelect = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
        @(negedge clk);
        slaveAddr       = addr;
        slaveRead       = 1'b1;
        slaveChipSelect = 1'b1;
        @(negedge clk);
        slaveRead       = 1'b0;
        slaveChipSelect = 1'b0;
        data = slaveReadData;
    endtask

    task automatic readWriteSame(input logic [4:0] addr, input logic [31:0] data, output logic [31:0] rd);
        @(negedge clk);
        slaveAddr       = addr;
        slaveWriteData  = data;
        slaveWrite      = 1'b1;
        slaveRead       = 1'b1;
        slaveChipSelect = 1'b1;
        @(negedge clk);
        slaveWrite      = 1'b0;
        slaveRead       = 1'b0;
        slaveChipSelect = 1'b0;
        rd = slaveReadData;
    endtask

    task automatic pulseDone(input int idx);
        @(negedge clk);
        coreDone[idx] = 1'b1;
        @(negedge clk);
        coreDone = '0;
    endtask

    initial begin
        n_rst           = 1'b0;
        slaveAddr       = '0;
        slaveWriteData  = '0;
        slaveWrite      = 1'b0;
        slaveRead       = 1'b0;
        slaveChipSelect = 1'b0;
        coreFound       = '0;
        coreNonce       = '0;
        coreDone        = '0;

        // Reset values
        #1;
        checkOutput("rst_readdata", slaveReadData, 0);
        checkOutput("rst_start", coreStart, 0);
        checkOutput("rst_abort", coreAbort, 0);
        checkOutput("rst_target", coreTarget, 0);
        checkOutput("rst_msg_lo", coreMessage[255:0], 0);
        @(negedge clk);
        n_rst = 1'b1;
        readReg(5'd0, rdata);
        checkOutput("rst_status", rdata, 0);

        // Constant nonce partition
        checkOutput("nonce_base", coreNonceBase, 128'hC0000000_80000000_40000000_00000000);

        // Load target and mark it ready
        applyStimulus(5'd9, 32'h0100_0000);
        for (int a = 8; a >= 2; a--) applyStimulus(5'(a), 32'h0);
        applyStimulus(5'd1, 32'd1);
        readReg(5'd0, rdata);
        checkOutput("status_tgt_ready", rdata, 1);
        checkOutput("target_value", coreTarget, {8'h01, 248'h0});

        // Message and start
        applyStimulus(5'd11, 32'h0000_0061);
        for (int a = 12; a <= 29; a++) applyStimulus(5'(a), 32'h0);
        applyStimulus(5'd1, 32'd2);
        checkOutput("start_pulse_hi", coreStart, 1);
        @(negedge clk);
        checkOutput("start_pulse_lo", coreStart, 0);
        checkOutput("msg_word0", coreMessage[31:0], 32'h61);
        readReg(5'd0, rdata);
        checkOutput("status_mining", rdata, 2);

        // Target write ignored while mining
        applyStimulus(5'd2, 32'hDEAD_BEEF);
        checkOutput("target_frozen", coreTarget, {8'h01, 248'h0});

        // Single hit on core 2
        @(negedge clk);
        coreFound[2] = 1'b1;
        coreNonce[64 +: 32] = 32'h8000_1234;
        @(negedge clk);
        coreFound = '0;
        checkOutput("found_abort_hi", coreAbort, 1);
        @(negedge clk);
        checkOutput("found_abort_lo", coreAbort, 0);
        readReg(5'd0, rdata);
        checkOutput("status_found", rdata, 3);
        readReg(5'd10, rdata);
        checkOutput("nonce_core2", rdata, 32'h8000_1234);
        readReg(5'd30, rdata);
        checkOutput("found_core2", rdata, 2);

        // Restart from FOUND; simultaneous hits on cores 1 and 3
        applyStimulus(5'd1, 32'd2);
        checkOutput("restart_pulse", coreStart, 1);
        @(negedge clk);
        coreFound = 4'b1010;
        coreNonce[32 +: 32] = 32'h4000_0007;
        coreNonce[96 +: 32] = 32'hC000_0009;
        @(negedge clk);
        coreFound = '0;
        checkOutput("tie_abort", coreAbort, 1);
        readReg(5'd10, rdata);
        checkOutput("nonce_tie", rdata, 32'h4000_0007);
        readReg(5'd30, rdata);
        checkOutput("found_core_tie", rdata, 1);

        // FOUND -> TGT_READY -> MINING, staggered exhaustion
        applyStimulus(5'd1, 32'd1);
        readReg(5'd0, rdata);
        checkOutput("found_to_ready", rdata, 1);
        applyStimulus(5'd1, 32'd2);
        pulseDone(0);
        pulseDone(1);
        pulseDone(2);
        readReg(5'd0, rdata);
        checkOutput("status_partial_done", rdata, 2);
        pulseDone(3);
        checkOutput("exhaust_no_abort", coreAbort, 0);
        readReg(5'd0, rdata);
        checkOutput("status_exhausted", rdata, 4);

        // Restart from EXHAUSTED (mask cleared); hit coincident with last done
        applyStimulus(5'd1, 32'd2);
        pulseDone(0);
        pulseDone(1);
        pulseDone(2);
        readReg(5'd0, rdata);
        checkOutput("mask_cleared", rdata, 2);
        @(negedge clk);
        coreDone[3]  = 1'b1;
        coreFound[0] = 1'b1;
        coreNonce[0 +: 32] = 32'h0000_0042;
        @(negedge clk);
        coreDone  = '0;
        coreFound = '0;
        readReg(5'd0, rdata);
        checkOutput("found_beats_done", rdata, 3);
        readReg(5'd10, rdata);
        checkOutput("nonce_core0", rdata, 32'h42);

        // Abort command
        applyStimulus(5'd1, 32'd1);
        applyStimulus(5'd1, 32'd2);
        applyStimulus(5'd1, 32'd3);
        checkOutput("abort_pulse_hi", coreAbort, 1);
        @(negedge clk);
        checkOutput("abort_pulse_lo", coreAbort, 0);
        readReg(5'd0, rdata);
        checkOutput("status_after_abort", rdata, 1);
        applyStimulus(5'd1, 32'd3);
        checkOutput("abort_ignored", coreAbort, 0);

        // Read/write same cycle returns old data, read data holds
        applyStimulus(5'd3, 32'h1111_1111);
        readWriteSame(5'd3, 32'h2222_2222, rdata);
        checkOutput("rw_same_old", rdata, 32'h1111_1111);
        readReg(5'd3, rdata);
        checkOutput("rw_same_new", rdata, 32'h2222_2222);
        applyStimulus(5'd3, 32'h3333_3333);
        @(negedge clk);
        checkOutput("readdata_hold", slaveReadData, 32'h2222_2222);
        readReg(5'd1, rdata);
        checkOutput("control_reads_zero", rdata, 0);

        // Reset mid-job
        applyStimulus(5'd1, 32'd2);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checkOutput("midjob_rst_abort", coreAbort, 0);
        checkOutput("midjob_rst_target", coreTarget, 0);
        @(negedge clk);
        n_rst = 1'b1;
        readReg(5'd0, rdata);
        checkOutput("midjob_rst_status", rdata, 0);
        applyStimulus(5'd1, 32'd2);
        checkOutput("idle_start_ignored", coreStart, 0);
        readReg(5'd0, rdata);
        checkOutput("idle_status", rdata, 0);

        // Read-only and unmapped addresses
        applyStimulus(5'd10, 32'hFFFF_FFFF);
        readReg(5'd10, rdata);
        checkOutput("nonce_ro", rdata, 0);
        applyStimulus(5'd30, 32'h0000_0003);
        readReg(5'd30, rdata);
        checkOutput("found_core_ro", rdata, 0);
        applyStimulus(5'd0, 32'h0000_0002);
        readReg(5'd0, rdata);
        checkOutput("status_ro", rdata, 0);
        readReg(5'd31, rdata);
        checkOutput("addr31_after_rst", rdata, 0);

`ifdef MINER_IRQ_EN
        // Interrupt path
        applyStimulus(5'd31, 32'd1);
        applyStimulus(5'd1, 32'd1);
        applyStimulus(5'd1, 32'd2);
        @(negedge clk);
        coreFound[3] = 1'b1;
        coreNonce[96 +: 32] = 32'hC000_0001;
        @(negedge clk);
        coreFound = '0;
        @(negedge clk);
        checkOutput("irq_set", irq, 1);
        readReg(5'd31, rdata);
        checkOutput("irq_ctrl_read", rdata, 3);
        applyStimulus(5'd31, 32'd3);
        @(negedge clk);
        checkOutput("irq_cleared", irq, 0);
`else
        applyStimulus(5'd31, 32'h0000_0003);
        readReg(5'd31, rdata);
        checkOutput("addr31_absent", rdata, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
